// File: rtl/dcache_responder_pkg.sv
// Shared types and constants for the L1 data cache responder.
// Holds the FSM encoding, the memory request record and the byte-merge helper.
package dcache_responder_pkg;

    localparam int DCACHE_XLEN     = 64;
    localparam int CACHELINE_SIZE  = 8;
    localparam int NR_MSHR_ENTRIES = 1;
    localparam int DCACHE_NR_SETS  = 64;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HIT_RSP   = 3'd1,
        MISS_REQ  = 3'd2,
        MISS_WAIT = 3'd3,
        MISS_RSP  = 3'd4,
        WR_REQ    = 3'd5
    } dcache_state_e;

    typedef struct packed {
        logic                   we;
        logic [DCACHE_XLEN-1:0] addr;
        logic [DCACHE_XLEN-1:0] wdata;
        logic [7:0]             wmask;
    } mem_req_t;

    // Overlay the enabled byte lanes of new_data onto old_line.
    function automatic logic [DCACHE_XLEN-1:0] merge_bytes(
        input logic [DCACHE_XLEN-1:0] old_line,
        input logic [DCACHE_XLEN-1:0] new_data,
        input logic [7:0]             mask
    );
        logic [DCACHE_XLEN-1:0] res;
        res = old_line;
        for (int b = 0; b < 8; b++) begin
            if (mask[b]) begin
                res[8*b +: 8] = new_data[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_line[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dcache_responder_if.sv
// LSU-side port bundle of the data cache: load request/response and committed-store channel.
// The LSU drives the master modport, the cache implements the slave modport.
interface dcache_ports_if
    import dcache_responder_pkg::*;
#(
    parameter int XLEN = DCACHE_XLEN
);
    logic [XLEN-1:0] load_a_addr;
    logic            load_a_valid;
    logic            load_a_ready;
    logic [XLEN-1:0] load_d_data;
    logic            load_d_valid;
    logic [XLEN-1:0] waddr;
    logic [XLEN-1:0] wdata;
    logic [7:0]      wmask;
    logic            wvalid;
    logic            wready;

    modport master (
        output load_a_addr, load_a_valid, waddr, wdata, wmask, wvalid,
        input  load_a_ready, load_d_data, load_d_valid, wready
    );

    modport slave (
        input  load_a_addr, load_a_valid, waddr, wdata, wmask, wvalid,
        output load_a_ready, load_d_data, load_d_valid, wready
    );
endinterface

// File: rtl/dcache_dm_array.sv
// Direct-mapped valid/tag/data storage: combinational read, byte-masked write, full-line fill.
// Only the valid bits are reset; tag and data contents are qualified by them.
module dcache_dm_array
    import dcache_responder_pkg::*;
#(
    parameter int XLEN    = DCACHE_XLEN,
    parameter int NR_SETS = DCACHE_NR_SETS,
    parameter int IDX_W   = $clog2(NR_SETS),
    parameter int TAG_W   = XLEN - 3 - IDX_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [XLEN-1:0]  rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [XLEN-1:0]  wr_data,
    input  logic [7:0]       wr_mask,
    input  logic             fill_en,
    input  logic [IDX_W-1:0] fill_idx,
    input  logic [TAG_W-1:0] fill_tag,
    input  logic [XLEN-1:0]  fill_data
);

    logic [NR_SETS-1:0] valid_r;
    logic [TAG_W-1:0]   tag_r  [NR_SETS];
    logic [XLEN-1:0]    data_r [NR_SETS];

    // Line valid bits, set by a refill and cleared only by reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_r <= '0;
        end else if (fill_en) begin
            valid_r[fill_idx] <= 1'b1;
        end
    end

    // Tag/data storage; a refill and a store hit never coincide, fill wins anyway.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_r[fill_idx]  <= fill_tag;
            data_r[fill_idx] <= fill_data;
        end else if (wr_en) begin
            data_r[wr_idx] <= merge_bytes(data_r[wr_idx], wr_data, wr_mask);
        end
    end

    assign rd_valid = valid_r[rd_idx];
    assign rd_tag   = tag_r[rd_idx];
    assign rd_data  = data_r[rd_idx];

endmodule

// File: rtl/dcache_responder.sv
// Blocking direct-mapped write-through, no-write-allocate L1 data cache with one-doubleword lines.
// Misses and every store go out on a single-outstanding memory request/response port.
module dcache_responder
    import dcache_responder_pkg::*;
#(
    parameter int XLEN    = DCACHE_XLEN,
    parameter int NR_SETS = DCACHE_NR_SETS
) (
    input  logic            clk,
    input  logic            rstn,
    dcache_ports_if.slave   dcache_ports_io,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic            mem_req_we,
    output logic [XLEN-1:0] mem_req_addr,
    output logic [XLEN-1:0] mem_req_wdata,
    output logic [7:0]      mem_req_wmask,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data
);

    localparam int IDX_W = $clog2(NR_SETS);
    localparam int TAG_W = XLEN - 3 - IDX_W;
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-3){1'b1}}, 3'b000};

    dcache_state_e state_r;
    dcache_state_e next_state_s;

    logic            ready_r;
    logic            load_d_valid_r;
    logic [XLEN-1:0] load_d_data_r;
    logic            mem_req_valid_r;
    mem_req_t        req_r;

    logic [XLEN-4:0]  lk_line_s;
    logic [IDX_W-1:0] lk_idx_s;
    logic [TAG_W-1:0] lk_tag_s;
    logic             rd_valid_s;
    logic [TAG_W-1:0] rd_tag_s;
    logic [XLEN-1:0]  rd_data_s;
    logic             hit_s;
    logic             store_acc_s;
    logic             load_acc_s;
    logic             fill_en_s;

    // Stores win the lookup port because they are already committed.
    assign lk_line_s = dcache_ports_io.wvalid ? dcache_ports_io.waddr[XLEN-1:3]
                                              : dcache_ports_io.load_a_addr[XLEN-1:3];
    assign lk_idx_s  = lk_line_s[IDX_W-1:0];
    assign lk_tag_s  = lk_line_s[XLEN-4 -: TAG_W];
    assign hit_s     = rd_valid_s && (rd_tag_s == lk_tag_s);

    dcache_dm_array #(
        .XLEN    (XLEN),
        .NR_SETS (NR_SETS),
        .IDX_W   (IDX_W),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk       (clk),
        .rstn      (rstn),
        .rd_idx    (lk_idx_s),
        .rd_valid  (rd_valid_s),
        .rd_tag    (rd_tag_s),
        .rd_data   (rd_data_s),
        .wr_en     (store_acc_s && hit_s),
        .wr_idx    (lk_idx_s),
        .wr_data   (dcache_ports_io.wdata),
        .wr_mask   (dcache_ports_io.wmask),
        .fill_en   (fill_en_s),
        .fill_idx  (req_r.addr[3 +: IDX_W]),
        .fill_tag  (req_r.addr[XLEN-1 -: TAG_W]),
        .fill_data (mem_rsp_data)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode and single-cycle control strobes.
    always_comb begin
        next_state_s = state_r;
        store_acc_s  = 1'b0;
        load_acc_s   = 1'b0;
        fill_en_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (ready_r && dcache_ports_io.wvalid) begin
                    store_acc_s  = 1'b1;
                    next_state_s = WR_REQ;
                end else if (ready_r && dcache_ports_io.load_a_valid) begin
                    load_acc_s   = 1'b1;
                    next_state_s = hit_s ? HIT_RSP : MISS_REQ;
                end else begin
                    next_state_s = IDLE;
                end
            end
            HIT_RSP: next_state_s = IDLE;
            MISS_REQ: begin
                if (mem_req_ready) begin
                    next_state_s = MISS_WAIT;
                end else begin
                    next_state_s = MISS_REQ;
                end
            end
            MISS_WAIT: begin
                if (mem_rsp_valid) begin
                    fill_en_s    = 1'b1;
                    next_state_s = MISS_RSP;
                end else begin
                    next_state_s = MISS_WAIT;
                end
            end
            MISS_RSP: next_state_s = IDLE;
            WR_REQ: begin
                if (mem_req_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = WR_REQ;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Output flags track the state being entered so they line up with state_r.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ready_r         <= 1'b0;
            load_d_valid_r  <= 1'b0;
            mem_req_valid_r <= 1'b0;
        end else begin
            ready_r         <= (next_state_s == IDLE);
            load_d_valid_r  <= (next_state_s == HIT_RSP) || (next_state_s == MISS_RSP);
            mem_req_valid_r <= (next_state_s == MISS_REQ) || (next_state_s == WR_REQ);
        end
    end

    // Request record only changes on acceptance in IDLE, so it is stable while waiting for ready.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_r <= '0;
        end else if (store_acc_s) begin
            req_r.we    <= 1'b1;
            req_r.addr  <= dcache_ports_io.waddr & ALIGN_MASK;
            req_r.wdata <= dcache_ports_io.wdata;
            req_r.wmask <= dcache_ports_io.wmask;
        end else if (load_acc_s) begin
            req_r.we    <= 1'b0;
            req_r.addr  <= dcache_ports_io.load_a_addr & ALIGN_MASK;
            req_r.wdata <= '0;
            req_r.wmask <= 8'h00;
        end
    end

    // Response data: hit line at acceptance, or refill data as it arrives.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            load_d_data_r <= '0;
        end else if (load_acc_s && hit_s) begin
            load_d_data_r <= rd_data_s;
        end else if (fill_en_s) begin
            load_d_data_r <= mem_rsp_data;
        end
    end

    assign dcache_ports_io.wready       = ready_r;
    assign dcache_ports_io.load_a_ready = ready_r & ~dcache_ports_io.wvalid;
    assign dcache_ports_io.load_d_valid = load_d_valid_r;
    assign dcache_ports_io.load_d_data  = load_d_data_r;

    assign mem_req_valid = mem_req_valid_r;
    assign mem_req_we    = req_r.we;
    assign mem_req_addr  = req_r.addr;
    assign mem_req_wdata = req_r.wdata;
    assign mem_req_wmask = req_r.wmask;

endmodule

// File: tb/tb_dcache_responder.sv
// Self-checking bench for dcache_responder: vector table, load scoreboard, memory model with latency.
module tb_dcache_responder;
    import dcache_responder_pkg::*;

    localparam int BUDGET  = 200;
    localparam int MEM_LAT = 3;

    typedef struct {
        logic        is_store;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic        exp_hit;
        logic [63:0] exp_data;
    } vec_t;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } req_t;

    logic        clk;
    logic        rstn;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [63:0] mem_req_addr;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_data;

    dcache_ports_if dport ();

    dcache_responder dut (
        .clk             (clk),
        .rstn            (rstn),
        .dcache_ports_io (dport),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_we      (mem_req_we),
        .mem_req_addr    (mem_req_addr),
        .mem_req_wdata   (mem_req_wdata),
        .mem_req_wmask   (mem_req_wmask),
        .mem_rsp_valid   (mem_rsp_valid),
        .mem_rsp_data    (mem_rsp_data)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int acc_cyc = 0;
    int last_lat = 0;
    int n_rsp  = 0;

    logic [63:0] sb_q[$];
    req_t        req_log[$];
    logic [63:0] phys_mem [logic [63:0]];
    bit          stray = 1'b0;
    vec_t        vecs[15];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        if (phys_mem.exists(a)) return phys_mem[a];
        return 64'h0;
    endfunction

    // Memory model: logs accepted requests, applies writes, answers reads after MEM_LAT edges.
    initial begin : mem_model
        int   rsp_cnt;
        logic [63:0] rsp_addr;
        bit   pend;
        req_t held;
        req_t cur;
        logic [63:0] m;
        rsp_cnt = 0;
        rsp_addr = 64'h0;
        pend = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 64'h0;
        forever begin
            @(posedge clk);
            if (!rstn) begin
                rsp_cnt = 0;
                pend = 1'b0;
            end else begin
                cur = '{we: mem_req_we, addr: mem_req_addr, wdata: mem_req_wdata, wmask: mem_req_wmask};
                if (pend) begin
                    n_cmp++;
                    if (!mem_req_valid || cur.we !== held.we || cur.addr !== held.addr ||
                        cur.wdata !== held.wdata || cur.wmask !== held.wmask) begin
                        n_fail++;
                        $display("FAIL req_stable: got v=%b addr=%h expected v=1 addr=%h",
                                 mem_req_valid, cur.addr, held.addr);
                    end
                end
                pend = mem_req_valid && !mem_req_ready;
                held = cur;
                if (mem_req_valid && mem_req_ready) begin
                    req_log.push_back(cur);
                    if (cur.we) begin
                        m = mem_rd(cur.addr);
                        for (int b = 0; b < 8; b++)
                            if (cur.wmask[b]) m[8*b +: 8] = cur.wdata[8*b +: 8];
                        phys_mem[cur.addr] = m;
                    end else begin
                        rsp_cnt  = MEM_LAT;
                        rsp_addr = cur.addr;
                    end
                end
            end
            #1;
            mem_rsp_valid = 1'b0;
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = mem_rd(rsp_addr);
                end
            end else if (stray) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = 64'hDEADBEEFDEADBEEF;
                stray = 1'b0;
            end
            mem_req_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Response monitor: every load_d_valid pulse must match the oldest expected load.
    initial forever begin
        logic [63:0] e;
        @(negedge clk);
        if (rstn && dport.load_d_valid) begin
            last_lat = cyc - acc_cyc;
            n_rsp++;
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_rsp: got data %h expected no response", dport.load_d_data);
            end else begin
                e = sb_q.pop_front();
                if (dport.load_d_data !== e) begin
                    n_fail++;
                    $display("FAIL load_data: got %h expected %h", dport.load_d_data, e);
                end
            end
        end
    end

    task automatic wait_idle(input string nm);
        int w = 0;
        while (!dport.wready && w < BUDGET) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (w >= BUDGET) check({nm, "_idle_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic wait_load_ready(output bit ok);
        int w = 0;
        while (!dport.load_a_ready && w < BUDGET) begin
            @(negedge clk);
            #1;
            w++;
        end
        ok = (w < BUDGET);
        if (!ok) check("load_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_rsp();
        int w = 0;
        while (sb_q.size() != 0 && w < BUDGET) begin
            @(negedge clk);
            #2;
            w++;
        end
        if (w >= BUDGET) check("load_rsp_timeout", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic do_load(input vec_t v);
        bit ok;
        req_log.delete();
        @(negedge clk);
        dport.load_a_addr  = v.addr;
        dport.load_a_valid = 1'b1;
        #1;
        wait_load_ready(ok);
        if (!ok) begin
            dport.load_a_valid = 1'b0;
            return;
        end
        acc_cyc = cyc;
        sb_q.push_back(v.exp_data);
        @(posedge clk);
        #1;
        dport.load_a_valid = 1'b0;
        wait_rsp();
        wait_idle("load");
        check("load_mem_reads", 64'(req_log.size()), v.exp_hit ? 64'd0 : 64'd1);
        if (v.exp_hit) begin
            check("hit_latency", 64'(last_lat), 64'd1);
        end else if (req_log.size() == 1) begin
            check("miss_req_we", {63'd0, req_log[0].we}, 64'd0);
            check("miss_req_addr", req_log[0].addr, v.addr & ~64'h7);
        end
    endtask

    task automatic do_store(input vec_t v);
        int w = 0;
        req_log.delete();
        @(negedge clk);
        dport.waddr  = v.addr;
        dport.wdata  = v.wdata;
        dport.wmask  = v.wmask;
        dport.wvalid = 1'b1;
        #1;
        while (!dport.wready && w < BUDGET) begin
            @(negedge clk);
            #1;
            w++;
        end
        @(posedge clk);
        #1;
        dport.wvalid = 1'b0;
        wait_idle("store");
        check("store_mem_reqs", 64'(req_log.size()), 64'd1);
        if (req_log.size() == 1) begin
            check("store_we", {63'd0, req_log[0].we}, 64'd1);
            check("store_addr", req_log[0].addr, v.addr & ~64'h7);
            check("store_wdata", req_log[0].wdata, v.wdata);
            check("store_wmask", {56'd0, req_log[0].wmask}, {56'd0, v.wmask});
        end
    endtask

    initial begin : main
        bit ok;
        int rsp_before;
        vec_t v;

        phys_mem[64'h1000] = 64'h1122334455667788;
        phys_mem[64'h1008] = 64'h5555AAAA5555AAAA;
        phys_mem[64'h1018] = 64'h3333444455556666;
        phys_mem[64'h1200] = 64'h0123456789ABCDEF;
        phys_mem[64'h11F8] = 64'h0F0F0F0F0F0F0F0F;
        phys_mem[64'h2000] = 64'hCAFEF00D12345678;

        //             store  addr          wdata                  mask   hit   expected load data
        vecs[0]  = '{1'b0, 64'h1000, 64'h0,                 8'h00, 1'b0, 64'h1122334455667788};
        vecs[1]  = '{1'b0, 64'h1004, 64'h0,                 8'h00, 1'b1, 64'h1122334455667788};
        vecs[2]  = '{1'b1, 64'h1000, 64'h00000000AB000000,  8'h08, 1'b1, 64'h0};
        vecs[3]  = '{1'b0, 64'h1000, 64'h0,                 8'h00, 1'b1, 64'h11223344AB667788};
        vecs[4]  = '{1'b1, 64'h2000, 64'h00000000000000EE,  8'h01, 1'b0, 64'h0};
        vecs[5]  = '{1'b0, 64'h2000, 64'h0,                 8'h00, 1'b0, 64'hCAFEF00D123456EE};
        vecs[6]  = '{1'b0, 64'h2004, 64'h0,                 8'h00, 1'b1, 64'hCAFEF00D123456EE};
        vecs[7]  = '{1'b0, 64'h1000, 64'h0,                 8'h00, 1'b0, 64'h11223344AB667788};
        vecs[8]  = '{1'b0, 64'h1200, 64'h0,                 8'h00, 1'b0, 64'h0123456789ABCDEF};
        vecs[9]  = '{1'b0, 64'h1000, 64'h0,                 8'h00, 1'b0, 64'h11223344AB667788};
        vecs[10] = '{1'b0, 64'h1008, 64'h0,                 8'h00, 1'b0, 64'h5555AAAA5555AAAA};
        vecs[11] = '{1'b1, 64'h1008, 64'hFFFF000000000000,  8'hC0, 1'b1, 64'h0};
        vecs[12] = '{1'b0, 64'h100C, 64'h0,                 8'h00, 1'b1, 64'hFFFFAAAA5555AAAA};
        vecs[13] = '{1'b0, 64'h11F8, 64'h0,                 8'h00, 1'b0, 64'h0F0F0F0F0F0F0F0F};
        vecs[14] = '{1'b0, 64'h11FC, 64'h0,                 8'h00, 1'b1, 64'h0F0F0F0F0F0F0F0F};

        dport.load_a_addr  = 64'h0;
        dport.load_a_valid = 1'b0;
        dport.waddr  = 64'h0;
        dport.wdata  = 64'h0;
        dport.wmask  = 8'h00;
        dport.wvalid = 1'b0;
        rstn = 1'b1;
        #1 rstn = 1'b0;
        #3;
        check("rst_load_a_ready", {63'd0, dport.load_a_ready}, 64'd0);
        check("rst_wready", {63'd0, dport.wready}, 64'd0);
        check("rst_load_d_valid", {63'd0, dport.load_d_valid}, 64'd0);
        check("rst_mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].is_store) do_store(vecs[i]);
            else                  do_load(vecs[i]);
        end

        // Store and load presented together: the store must win and the load wait for WR_REQ.
        req_log.delete();
        @(negedge clk);
        dport.waddr = 64'h1008;
        dport.wdata = 64'h0000000000000011;
        dport.wmask = 8'h01;
        dport.wvalid = 1'b1;
        dport.load_a_addr = 64'h1008;
        dport.load_a_valid = 1'b1;
        #1;
        check("tie_wready", {63'd0, dport.wready}, 64'd1);
        check("tie_load_a_ready", {63'd0, dport.load_a_ready}, 64'd0);
        @(posedge clk);
        #1;
        dport.wvalid = 1'b0;
        check("tie_wr_req_valid", {62'd0, mem_req_valid, mem_req_we}, 64'd3);
        check("tie_load_blocked", {63'd0, dport.load_a_ready}, 64'd0);
        wait_load_ready(ok);
        if (ok) begin
            acc_cyc = cyc;
            sb_q.push_back(64'hFFFFAAAA5555AA11);
            @(posedge clk);
            #1;
            dport.load_a_valid = 1'b0;
            wait_rsp();
            wait_idle("tie");
            check("tie_reqs", 64'(req_log.size()), 64'd1);
            if (req_log.size() == 1) check("tie_req_is_write", {63'd0, req_log[0].we}, 64'd1);
            check("tie_hit_latency", 64'(last_lat), 64'd1);
        end else begin
            dport.load_a_valid = 1'b0;
        end

        // Reset while a miss waits on memory: aborted load must never respond.
        req_log.delete();
        rsp_before = n_rsp;
        @(negedge clk);
        dport.load_a_addr = 64'h1018;
        dport.load_a_valid = 1'b1;
        #1;
        wait_load_ready(ok);
        if (ok) begin
            @(posedge clk);
            #1;
            dport.load_a_valid = 1'b0;
            for (int w = 0; w < BUDGET && req_log.size() == 0; w++) @(negedge clk);
            check("rst_miss_issued", 64'(req_log.size()), 64'd1);
            rstn = 1'b0;
            #1;
            check("arst_load_a_ready", {63'd0, dport.load_a_ready}, 64'd0);
            check("arst_wready", {63'd0, dport.wready}, 64'd0);
            check("arst_load_d_valid", {63'd0, dport.load_d_valid}, 64'd0);
            check("arst_mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
            repeat (3) @(negedge clk);
            rstn = 1'b1;
            stray = 1'b1;
            repeat (6) @(negedge clk);
            check("aborted_no_rsp", 64'(n_rsp - rsp_before), 64'd0);
        end else begin
            dport.load_a_valid = 1'b0;
        end

        v = '{1'b0, 64'h1000, 64'h0, 8'h00, 1'b0, 64'h11223344AB667788};
        do_load(v);

        repeat (10) @(negedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Responder end of dcache_ports_if. Serves the LSU load channel (load_a/load_d) and the committed-store write channel (w*).
- Blocking, direct-mapped, write-through, no-write-allocate cache. Line size is one doubleword (8 bytes).
- Misses and all stores go to a simple single-outstanding memory request/response port.
- Sits between fu_lsu and the memory model / L2 stub.

Parameters:
- XLEN, 64, data and physical address width.
- NR_SETS, 64, number of lines (power of 2). IDX_W = log2(NR_SETS).
- TAG_W, XLEN-3-IDX_W, tag width.

Ports:
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- dcache_ports_io.load_a_addr  in  XLEN  load physical address
- dcache_ports_io.load_a_valid  in  1  load request
- dcache_ports_io.load_a_ready  out  1  load request accepted when valid&ready
- dcache_ports_io.load_d_data  out  XLEN  full aligned doubleword (LSU does the merge and extension)
- dcache_ports_io.load_d_valid  out  1  single-cycle response pulse
- dcache_ports_io.waddr  in  XLEN  store address
- dcache_ports_io.wdata  in  XLEN  store data, already lane-shifted
- dcache_ports_io.wmask  in  8  byte enables
- dcache_ports_io.wvalid  in  1  store request
- dcache_ports_io.wready  out  1  store accepted when wvalid&wready
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  1 = write, 0 = doubleword read
- mem_req_addr  out  XLEN  address, bits [2:0] forced to 0
- mem_req_wdata  out  XLEN  write data
- mem_req_wmask  out  8  write byte enables
- mem_rsp_valid  in  1  read data valid (reads only; writes get no response)
- mem_rsp_data  in  XLEN  read data

Behaviour:
- Address split: idx = addr[3+:IDX_W]; tag = addr[XLEN-1:3+IDX_W]. Bits [2:0] are ignored.
- Storage: valid[NR_SETS] is reset to 0. Tag and data arrays are not reset.
- Reset values: load_a_ready=0, wready=0, load_d_valid=0, mem_req_valid=0, state=IDLE.
- FSM states: IDLE, HIT_RSP, MISS_REQ, MISS_WAIT, MISS_RSP, WR_REQ.
- IDLE:
  - wready=1; load_a_ready = !wvalid (stores win ties, since they are already committed).
  - Store accepted: latch addr/data/mask. If hit, merge the masked bytes into the data array the same cycle. Go to WR_REQ.
  - Load accepted: latch addr. Hit -> HIT_RSP. Miss -> MISS_REQ.
- HIT_RSP: load_d_valid=1 with the line data. Go to IDLE. Hit latency is exactly 1 cycle after acceptance.
- MISS_REQ: mem_req_valid=1, we=0, aligned address. Held until mem_req_ready, then MISS_WAIT.
- MISS_WAIT: on mem_rsp_valid, fill the line (valid=1, tag, data) and register the data. Go to MISS_RSP.
- MISS_RSP: load_d_valid=1 with the refilled data. Go to IDLE.
- WR_REQ: mem_req_valid=1, we=1, latched addr/data/mask. Go to IDLE on mem_req_ready. A write miss does not allocate.
- Outside IDLE, both ready outputs are 0. At most one load is outstanding and responses are in order (the LSU has no load_d_ready).
- load_d_valid fires exactly once per accepted load, never otherwise.
- mem_req_* stay stable while valid && !ready.
- A load that misses to the same index as a just-written hit line sees the merged data: the write lands before the next IDLE acceptance.
- Wrap-around / boundary: idx uses only IDX_W bits. Addresses NR_SETS*8 apart alias to the same set and are distinguished by tag.
- Async reset mid-miss or mid-write: returns to IDLE immediately, clears valid[], aborts any pending request. The memory model is reset together; a stray mem_rsp_valid in IDLE is ignored.
- An unexpected mem_rsp_valid outside MISS_WAIT is ignored.

Decomposition:
- Shared package (dahu pkg):
  - dcache_state_e
  - mem_req_t struct {we, addr, wdata, wmask}
  - DCACHE_NR_SETS constant, next to the existing CACHELINE_SIZE / NR_MSHR_ENTRIES
- Natural sub-module: dcache_dm_array (valid/tag/data storage):
  - async-reset valid bits
  - combinational read by idx
  - byte-masked write port
  - full-line fill port
- The FSM stays in dcache_responder.

Test Plan:
- Cold load 0x1000, memory returns 0x1122334455667788 after 3 cycles -> one mem read at 0x1000, load_d_data=0x1122334455667788 exactly once; repeat load 0x1004 -> hit, load_d_valid 1 cycle after acceptance, no mem request.
- Store waddr 0x1000, wdata 0x00000000AB000000, wmask 0x08 on the cached line -> mem write with mask 0x08; next load 0x1000 returns 0x11223344AB667788.
- Store to uncached 0x2000 -> mem write issued, valid[idx] unchanged; a following load 0x2000 misses.
- wvalid and load_a_valid asserted together in IDLE -> store accepted, load_a_ready=0 that cycle; load accepted only after WR_REQ completes.
- Aliasing: load 0x1000 then 0x1000+NR_SETS*8 (0x1200) -> second misses and evicts; reload 0x1000 misses again.
- Assert rstn=0 during MISS_WAIT -> all outputs return to reset values asynchronously; after release, load 0x1000 misses (valid cleared) and no load_d_valid is produced for the aborted load.
